// File: rtl/uart_trx_param.sv
// Parameterised UART transceiver with TX/RX FIFOs and sticky RX error flags.
// Optional internal loopback is built only when UART_TRX_LOOPBACK_EN is defined.

module uart_trx_param #(
    parameter int CLK_HZ     = 50000000,
    parameter int BAUD       = 115200,
    parameter int DATA_W     = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] tdata,
    input  logic              twrreq,
    output logic              tfull,
    output logic [DATA_W-1:0] rdata,
    input  logic              rdreq,
    output logic              rdempty,
    input  logic              uart_rxd,
    output logic              uart_txd,
    input  logic              loopback,
    input  logic              err_clr,
    output logic              rx_overrun,
    output logic              rx_frame_err,
    output logic              rx_parity_err
);

    localparam int BAUD_DIV_RAW = (CLK_HZ + BAUD / 2) / BAUD;
    localparam int BAUD_DIV     = (BAUD_DIV_RAW < 8) ? 8 : BAUD_DIV_RAW;
    localparam int CW           = $clog2(BAUD_DIV);
    localparam int AW           = $clog2(FIFO_DEPTH);
    localparam logic [CW-1:0] DIV_LAST  = CW'(BAUD_DIV - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(BAUD_DIV / 2 - 1);
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);
    localparam logic [AW:0]   PTR_ONE   = {{AW{1'b0}}, 1'b1};
    localparam logic [2:0]    BIT_LAST  = 3'(DATA_W - 1);
    localparam logic          STOP_LAST = 1'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_WAIT_HIGH
    } state_t;

    // ---------------- TX FIFO ----------------
    logic [DATA_W-1:0] tx_mem [FIFO_DEPTH];
    logic [AW:0]       tx_wptr, tx_rptr;
    logic              tx_empty, tx_push, tx_pop;

    assign tfull    = (tx_wptr[AW] != tx_rptr[AW]) && (tx_wptr[AW-1:0] == tx_rptr[AW-1:0]);
    assign tx_empty = (tx_wptr == tx_rptr);
    assign tx_push  = twrreq && !tfull;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_wptr <= '0;
            tx_rptr <= '0;
        end else begin
            if (tx_push) tx_wptr <= tx_wptr + PTR_ONE;
            if (tx_pop)  tx_rptr <= tx_rptr + PTR_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (tx_push) tx_mem[tx_wptr[AW-1:0]] <= tdata;
    end

    // ---------------- TX engine ----------------
    state_t            tx_state, tx_next;
    logic [CW-1:0]     tx_cnt;
    logic [2:0]        tx_bit;
    logic              tx_stop;
    logic [DATA_W-1:0] tx_data;
    logic              tx_tick, tx_par, tx_line;

    assign tx_tick = (tx_cnt == DIV_LAST);
    assign tx_par  = (PARITY == 1) ? ~(^tx_data) : ^tx_data;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_state <= S_IDLE;
            tx_cnt   <= '0;
            tx_bit   <= '0;
            tx_stop  <= 1'b0;
            tx_data  <= '0;
        end else begin
            tx_state <= tx_next;
            tx_cnt   <= (tx_state == S_IDLE || tx_tick) ? '0 : tx_cnt + CNT_ONE;
            if (tx_pop) tx_data <= tx_mem[tx_rptr[AW-1:0]];
            if (tx_state != S_DATA) tx_bit <= '0;
            else if (tx_tick)       tx_bit <= tx_bit + 3'd1;
            if (tx_state != S_STOP) tx_stop <= 1'b0;
            else if (tx_tick)       tx_stop <= ~tx_stop;
        end
    end

    // A new frame is fetched either from idle or straight out of the last stop cell.
    always_comb begin
        tx_next = tx_state;
        tx_pop  = 1'b0;
        case (tx_state)
            S_IDLE: if (!tx_empty) begin
                tx_next = S_START;
                tx_pop  = 1'b1;
            end
            S_START:  if (tx_tick) tx_next = S_DATA;
            S_DATA:   if (tx_tick && tx_bit == BIT_LAST) tx_next = (PARITY == 0) ? S_STOP : S_PARITY;
            S_PARITY: if (tx_tick) tx_next = S_STOP;
            S_STOP: if (tx_tick && tx_stop == STOP_LAST) begin
                if (!tx_empty) begin
                    tx_next = S_START;
                    tx_pop  = 1'b1;
                end else begin
                    tx_next = S_IDLE;
                end
            end
            default: tx_next = S_IDLE;
        endcase
    end

    always_comb begin
        tx_line = 1'b1;
        case (tx_state)
            S_START:  tx_line = 1'b0;
            S_DATA:   tx_line = tx_data[tx_bit];
            S_PARITY: tx_line = tx_par;
            default:  tx_line = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) uart_txd <= 1'b1;
        else        uart_txd <= tx_line;
    end

    // ---------------- RX input synchroniser ----------------
    logic rx_src, rx_s1, rx_s2, rx_prev, rx_fall;

`ifdef UART_TRX_LOOPBACK_EN
    assign rx_src = loopback ? uart_txd : uart_rxd;
`else
    logic unused_loopback;
    assign unused_loopback = loopback;
    assign rx_src          = uart_rxd;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_s1   <= 1'b1;
            rx_s2   <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_s1   <= rx_src;
            rx_s2   <= rx_s1;
            rx_prev <= rx_s2;
        end
    end

    assign rx_fall = rx_prev && !rx_s2;

    // ---------------- RX FIFO ----------------
    logic [DATA_W-1:0] rx_mem [FIFO_DEPTH];
    logic [AW:0]       rx_wptr, rx_rptr;
    logic              rx_full, rx_push, rx_pop;
    logic [DATA_W-1:0] rx_shift;

    assign rx_full = (rx_wptr[AW] != rx_rptr[AW]) && (rx_wptr[AW-1:0] == rx_rptr[AW-1:0]);
    assign rdempty = (rx_wptr == rx_rptr);
    assign rx_pop  = rdreq && !rdempty;
    assign rdata   = rx_mem[rx_rptr[AW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_wptr <= '0;
            rx_rptr <= '0;
        end else begin
            if (rx_push) rx_wptr <= rx_wptr + PTR_ONE;
            if (rx_pop)  rx_rptr <= rx_rptr + PTR_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (rx_push) rx_mem[rx_wptr[AW-1:0]] <= rx_shift;
    end

    // ---------------- RX engine ----------------
    state_t        rx_state, rx_next;
    logic [CW-1:0] rx_cnt;
    logic [2:0]    rx_bit;
    logic          rx_par, rx_sample, rx_par_bad, rx_good;
    logic          set_overrun, set_frame, set_parity;

    // The start cell is checked at half a cell; every later sample is one full cell on.
    assign rx_sample  = (rx_state == S_START) ? (rx_cnt == HALF_LAST) : (rx_cnt == DIV_LAST);
    assign rx_par_bad = (PARITY == 1) ? ~(^{rx_shift, rx_par}) : ^{rx_shift, rx_par};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_state <= S_IDLE;
            rx_cnt   <= '0;
            rx_bit   <= '0;
            rx_shift <= '0;
            rx_par   <= 1'b0;
        end else begin
            rx_state <= rx_next;
            rx_cnt   <= (rx_state == S_IDLE || rx_state == S_WAIT_HIGH || rx_sample) ? '0 : rx_cnt + CNT_ONE;
            if (rx_state != S_DATA) rx_bit <= '0;
            else if (rx_sample) begin
                rx_bit   <= rx_bit + 3'd1;
                rx_shift <= {rx_s2, rx_shift[DATA_W-1:1]};
            end
            if (rx_state == S_PARITY && rx_sample) rx_par <= rx_s2;
        end
    end

    always_comb begin
        rx_next = rx_state;
        case (rx_state)
            S_IDLE:      if (rx_fall) rx_next = S_START;
            S_START:     if (rx_sample) rx_next = rx_s2 ? S_IDLE : S_DATA;
            S_DATA:      if (rx_sample && rx_bit == BIT_LAST) rx_next = (PARITY == 0) ? S_STOP : S_PARITY;
            S_PARITY:    if (rx_sample) rx_next = S_STOP;
            S_STOP:      if (rx_sample) rx_next = rx_s2 ? S_IDLE : S_WAIT_HIGH;
            S_WAIT_HIGH: if (rx_s2) rx_next = S_IDLE;
            default:     rx_next = S_IDLE;
        endcase
    end

    always_comb begin
        rx_good     = (rx_state == S_STOP) && rx_sample && rx_s2;
        rx_push     = rx_good && !rx_full;
        set_overrun = rx_good && rx_full;
        set_frame   = (rx_state == S_STOP) && rx_sample && !rx_s2;
        set_parity  = rx_good && (PARITY != 0) && rx_par_bad;
    end

    // A set event in the same cycle as err_clr takes priority.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_overrun    <= 1'b0;
            rx_frame_err  <= 1'b0;
            rx_parity_err <= 1'b0;
        end else begin
            if (set_overrun)  rx_overrun <= 1'b1;
            else if (err_clr) rx_overrun <= 1'b0;
            if (set_frame)    rx_frame_err <= 1'b1;
            else if (err_clr) rx_frame_err <= 1'b0;
            if (set_parity)   rx_parity_err <= 1'b1;
            else if (err_clr) rx_parity_err <= 1'b0;
        end
    end

endmodule

// File: tb/tb_uart_trx_param.sv
// Directed bench for uart_trx_param: three instances (no parity / depth 4, even parity
// with TX->RX loop, odd parity) at BAUD_DIV=10.

module tb_uart_trx_param;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   check_cnt = 0;
    int   pass_cnt = 0;

    always #5 clk = ~clk;

    // Instance A: PARITY=0, FIFO_DEPTH=4
    logic [7:0] a_tdata, a_rdata;
    logic a_twrreq, a_tfull, a_rdreq, a_rdempty, a_rxd, a_txd, a_errclr;
    logic a_ovr, a_ferr, a_perr;
    // Instance B: PARITY=2, serial output looped back into its receiver
    logic [7:0] b_tdata, b_rdata;
    logic b_twrreq, b_tfull, b_rdreq, b_rdempty, b_rxd, b_txd, b_errclr, b_loop, b_ext;
    logic b_ovr, b_ferr, b_perr;
    // Instance C: PARITY=1
    logic [7:0] c_tdata, c_rdata;
    logic c_twrreq, c_tfull, c_rdreq, c_rdempty, c_rxd, c_txd, c_errclr;
    logic c_ovr, c_ferr, c_perr;
    logic lb_off = 1'b0;

    logic [7:0] rx_bytes [5] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
    logic [7:0] lb_bytes [3] = '{8'h3C, 8'h00, 8'hFF};

    assign b_rxd = b_ext ? b_txd : 1'b1;

    uart_trx_param #(.CLK_HZ(1000000), .BAUD(100000), .DATA_W(8), .PARITY(0),
                     .STOP_BITS(1), .FIFO_DEPTH(4)) dut_a (
        .clk(clk), .rst_n(rst_n), .tdata(a_tdata), .twrreq(a_twrreq), .tfull(a_tfull),
        .rdata(a_rdata), .rdreq(a_rdreq), .rdempty(a_rdempty), .uart_rxd(a_rxd),
        .uart_txd(a_txd), .loopback(lb_off), .err_clr(a_errclr), .rx_overrun(a_ovr),
        .rx_frame_err(a_ferr), .rx_parity_err(a_perr));

    uart_trx_param #(.CLK_HZ(1000000), .BAUD(100000), .DATA_W(8), .PARITY(2),
                     .STOP_BITS(1), .FIFO_DEPTH(4)) dut_b (
        .clk(clk), .rst_n(rst_n), .tdata(b_tdata), .twrreq(b_twrreq), .tfull(b_tfull),
        .rdata(b_rdata), .rdreq(b_rdreq), .rdempty(b_rdempty), .uart_rxd(b_rxd),
        .uart_txd(b_txd), .loopback(b_loop), .err_clr(b_errclr), .rx_overrun(b_ovr),
        .rx_frame_err(b_ferr), .rx_parity_err(b_perr));

    uart_trx_param #(.CLK_HZ(1000000), .BAUD(100000), .DATA_W(8), .PARITY(1),
                     .STOP_BITS(1), .FIFO_DEPTH(4)) dut_c (
        .clk(clk), .rst_n(rst_n), .tdata(c_tdata), .twrreq(c_twrreq), .tfull(c_tfull),
        .rdata(c_rdata), .rdreq(c_rdreq), .rdempty(c_rdempty), .uart_rxd(c_rxd),
        .uart_txd(c_txd), .loopback(lb_off), .err_clr(c_errclr), .rx_overrun(c_ovr),
        .rx_frame_err(c_ferr), .rx_parity_err(c_perr));

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        check_cnt++;
        if (got === exp) pass_cnt++;
        else $display("[TB] FAIL %s: got %0h, expected %0h", tag, got, exp);
    endtask

    task automatic waitCycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Serialises bits LSB first onto A (sel 0) or C (sel 1), then one idle cell.
    task automatic applyStimulus(input int sel, input logic [11:0] bits, input int nbits);
        for (int i = 0; i < nbits; i++) begin
            if (sel == 0) a_rxd = bits[i];
            else          c_rxd = bits[i];
            waitCycles(10);
        end
        if (sel == 0) a_rxd = 1'b1;
        else          c_rxd = 1'b1;
        waitCycles(10);
    endtask

    task automatic pushTx(input int sel, input logic [7:0] data);
        if (sel == 0) begin a_tdata = data; a_twrreq = 1'b1; end
        else          begin b_tdata = data; b_twrreq = 1'b1; end
        @(negedge clk);
        a_twrreq = 1'b0;
        b_twrreq = 1'b0;
    endtask

    task automatic popRx(input int sel, input logic [7:0] exp, input string tag);
        logic [7:0] got;
        case (sel)
            0:       got = a_rdata;
            1:       got = b_rdata;
            default: got = c_rdata;
        endcase
        checkOutput(tag, {24'h0, got}, {24'h0, exp});
        case (sel)
            0:       a_rdreq = 1'b1;
            1:       b_rdreq = 1'b1;
            default: c_rdreq = 1'b1;
        endcase
        @(negedge clk);
        a_rdreq = 1'b0;
        b_rdreq = 1'b0;
        c_rdreq = 1'b0;
    endtask

    task automatic pulseClear(input int sel);
        case (sel)
            0:       a_errclr = 1'b1;
            1:       b_errclr = 1'b1;
            default: c_errclr = 1'b1;
        endcase
        @(negedge clk);
        a_errclr = 1'b0;
        b_errclr = 1'b0;
        c_errclr = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        #400000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [8:0] tx_exp;
        int lows;
        a_tdata = '0; a_twrreq = 0; a_rdreq = 0; a_rxd = 1; a_errclr = 0;
        b_tdata = '0; b_twrreq = 0; b_rdreq = 0; b_errclr = 0;
        c_tdata = '0; c_twrreq = 0; c_rdreq = 0; c_rxd = 1; c_errclr = 0;
`ifdef UART_TRX_LOOPBACK_EN
        b_loop = 1'b1; b_ext = 1'b0;
`else
        b_loop = 1'b0; b_ext = 1'b1;
`endif
        waitCycles(3);
        checkOutput("rst_txd", a_txd, 1);
        checkOutput("rst_tfull", a_tfull, 0);
        checkOutput("rst_rdempty", a_rdempty, 1);
        checkOutput("rst_flags", {a_ovr, a_ferr, a_perr}, 0);
        checkOutput("rst_b_rdempty", b_rdempty, 1);
        rst_n = 1'b1;
        waitCycles(2);

        // Single 0xA5 frame, exact start edge and mid-cell values
        pushTx(0, 8'hA5);
        @(negedge clk);
        checkOutput("tx_idle_cycle1", a_txd, 1);
        @(negedge clk);
        checkOutput("tx_start_cycle2", a_txd, 0);
        waitCycles(9);
        checkOutput("tx_start_last", a_txd, 0);
        waitCycles(1);
        checkOutput("tx_bit0_first", a_txd, 1);
        waitCycles(5);
        tx_exp = {1'b1, 8'hA5};
        for (int i = 0; i < 9; i++) begin
            if (i > 0) waitCycles(10);
            checkOutput($sformatf("tx_cell%0d", i), a_txd, tx_exp[i]);
        end
        waitCycles(10);
        checkOutput("tx_idle_after", a_txd, 1);
        checkOutput("tx_tfull_low", a_tfull, 0);

        // Fill TX FIFO, then check back-to-back frames with no idle gap
        for (int i = 0; i < 5; i++) pushTx(0, 8'hFF);
        checkOutput("tx_tfull_set", a_tfull, 1);
        waitCycles(93);
        checkOutput("b2b_stop", a_txd, 1);
        waitCycles(10);
        checkOutput("b2b_next_start", a_txd, 0);
        checkOutput("b2b_tfull_drop", a_tfull, 0);
        waitCycles(500);
        checkOutput("b2b_drained", a_txd, 1);

        // Reset during data bit 3
        pushTx(0, 8'h00);
        pushTx(0, 8'h00);
        waitCycles(1);
        waitCycles(45);
        checkOutput("pre_rst_bit3", a_txd, 0);
        rst_n = 1'b0;
        #1;
        checkOutput("rst_async_txd", a_txd, 1);
        waitCycles(3);
        rst_n = 1'b1;
        waitCycles(1);
        checkOutput("post_rst_tfull", a_tfull, 0);
        lows = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (a_txd == 1'b0) lows++;
        end
        checkOutput("post_rst_no_bits", lows, 0);

        // RX overrun with depth 4
        for (int i = 0; i < 5; i++) applyStimulus(0, {3'b111, rx_bytes[i], 1'b0}, 10);
        checkOutput("ovr_set", a_ovr, 1);
        checkOutput("ovr_not_empty", a_rdempty, 0);
        checkOutput("ovr_no_ferr", a_ferr, 0);
        for (int i = 0; i < 4; i++) popRx(0, rx_bytes[i], $sformatf("ovr_pop%0d", i));
        checkOutput("ovr_empty_after", a_rdempty, 1);
        pulseClear(0);
        checkOutput("ovr_cleared", a_ovr, 0);

        // Framing error, then a short glitch
        applyStimulus(0, {3'b110, 8'h55, 1'b0}, 10);
        checkOutput("ferr_set", a_ferr, 1);
        checkOutput("ferr_rdempty", a_rdempty, 1);
        pulseClear(0);
        checkOutput("ferr_cleared", a_ferr, 0);
        a_rxd = 1'b0;
        waitCycles(3);
        a_rxd = 1'b1;
        waitCycles(30);
        checkOutput("glitch_rdempty", a_rdempty, 1);
        checkOutput("glitch_flags", {a_ovr, a_ferr, a_perr}, 0);

        // Even parity TX->RX loop
        for (int i = 0; i < 3; i++) pushTx(1, lb_bytes[i]);
        waitCycles(400);
        checkOutput("lb_not_empty", b_rdempty, 0);
        for (int i = 0; i < 3; i++) popRx(1, lb_bytes[i], $sformatf("lb_pop%0d", i));
        checkOutput("lb_empty", b_rdempty, 1);
        checkOutput("lb_flags", {b_ovr, b_ferr, b_perr}, 0);

        // Odd parity: 0x01 with parity 1 is wrong, 0x03 with parity 1 is right
        applyStimulus(1, {2'b11, 1'b1, 8'h01, 1'b0}, 11);
        checkOutput("par_err_set", c_perr, 1);
        popRx(2, 8'h01, "par_err_data");
        pulseClear(2);
        checkOutput("par_err_cleared", c_perr, 0);
        applyStimulus(1, {2'b11, 1'b1, 8'h03, 1'b0}, 11);
        checkOutput("par_ok_noerr", c_perr, 0);
        popRx(2, 8'h03, "par_ok_data");
        checkOutput("par_ok_ferr", c_ferr, 0);

        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule

// File: doc/uart_trx_param.md
UART_TRX_PARAM -- requirements
Module: uart_trx_param

Interface
REQ-001 Parameter CLK_HZ, default 50000000, system clock frequency in Hz.
REQ-002 Parameter BAUD, default 115200, line rate; BAUD_DIV = round(CLK_HZ/BAUD), minimum 8.
REQ-003 Parameter DATA_W, default 8, data bits per frame, legal range 5..8.
REQ-004 Parameter PARITY, default 0, parity mode: 0 none, 1 odd, 2 even.
REQ-005 Parameter STOP_BITS, default 1, stop bits per frame: 1 or 2.
REQ-006 Parameter FIFO_DEPTH, default 16, entries per TX and RX FIFO, power of 2, at least 2.
REQ-007 One clock, clk; reset rst_n is asynchronous, active-low.
REQ-008 Ports, in order:
- clk  in  1  system clock
- rst_n  in  1  async active-low reset
- tdata  in  DATA_W  TX write data
- twrreq  in  1  TX FIFO push
- tfull  out  1  TX FIFO full
- rdata  out  DATA_W  RX FIFO head (show-ahead)
- rdreq  in  1  RX FIFO pop
- rdempty  out  1  RX FIFO empty
- uart_rxd  in  1  serial input, asynchronous
- uart_txd  out  1  serial output, idle high
- loopback  in  1  internal loopback request
- err_clr  in  1  clear sticky error flags
- rx_overrun  out  1  sticky; RX byte dropped because RX FIFO full
- rx_frame_err  out  1  sticky; stop bit sampled low
- rx_parity_err  out  1  sticky; parity mismatch

Function
REQ-009 Baud tick: single counter 0..BAUD_DIV-1 per engine; all bit cells are exactly BAUD_DIV clk cycles long.
REQ-010 Frame format: start (0), DATA_W bits LSB first, optional parity bit, STOP_BITS stop bits (1).
REQ-011 TX FSM states: IDLE, START, DATA, PARITY, STOP; PARITY is skipped when PARITY=0.
REQ-012 TX leaves IDLE when the TX FIFO is non-empty; it pops one entry and uart_txd falls 2 clk cycles after the accepted twrreq (FIFO initially empty, TX idle).
REQ-013 Back-to-back frames: the next start bit immediately follows the last stop cell if the FIFO is non-empty; no extra idle cell is inserted.
REQ-014 RX input is passed through a 2-flop synchroniser before any use.
REQ-015 RX FSM states: IDLE, START, DATA, PARITY, STOP; a falling edge in IDLE enters START.
REQ-016 START: line re-sampled at BAUD_DIV/2; if high, the edge is a glitch and the FSM returns to IDLE with no write.
REQ-017 Data, parity and stop bits are sampled at mid-cell (BAUD_DIV cycles after the previous sample).
REQ-018 Only the first stop bit is checked; a low stop bit sets rx_frame_err, the byte is discarded, and the FSM waits for the line to go high before returning to IDLE.
REQ-019 A parity mismatch sets rx_parity_err; the byte is still written to the RX FIFO.
REQ-020 A good frame arriving while the RX FIFO is full is dropped and sets rx_overrun; FIFO contents are unchanged.
REQ-021 FIFO rules:
- push when full is ignored; pop when empty is ignored;
- simultaneous push and pop when non-empty leaves the count unchanged;
- pointers are log2(FIFO_DEPTH)+1 bits and wrap modulo 2*FIFO_DEPTH;
- full = MSBs differ and low bits equal.
REQ-022 rdata shows the RX head combinationally from RAM; it is undefined when rdempty=1.
REQ-023 err_clr clears all sticky flags next cycle; if a set event occurs in the same cycle, the set wins.

Reset
REQ-024 With rst_n low:
- uart_txd=1; tfull=0; rdempty=1;
- all error flags 0; both FSMs IDLE; FIFO pointers and baud counters 0.
REQ-025 Reset mid-frame aborts the frame immediately: uart_txd goes high asynchronously; the partial RX byte is discarded.

Configuration
REQ-026 Macro UART_TRX_LOOPBACK_EN.
- Defined: while loopback=1, the RX synchroniser input is uart_txd and uart_rxd is ignored; uart_txd still drives the pin.
- Undefined: loopback is ignored, no mux is built, and RX always uses uart_rxd.
- Toggling loopback mid-frame is illegal.

Verification (CLK_HZ=1000000, BAUD=100000 so BAUD_DIV=10; DATA_W=8)
REQ-027 PARITY=0: push 0xA5 -> uart_txd low at cycle +2, then bits 1,0,1,0,0,1,0,1 then 1, each cell 10 cycles; tfull stays 0.
REQ-028 Loopback defined, PARITY=2: push 0x3C, 0x00, 0xFF with loopback=1 -> rdata pops 0x3C, 0x00, 0xFF in order; no error flags set.
REQ-029 FIFO_DEPTH=4: drive 5 frames on uart_rxd with no pops -> 4 entries held, rx_overrun=1; pop 4 -> rdempty=1; pulse err_clr -> rx_overrun=0.
REQ-030 Drive 0x55 with stop bit low -> rx_frame_err=1, rdempty stays 1; a 3-cycle low glitch on idle uart_rxd -> no write, no flag.
REQ-031 PARITY=1: drive 0x01 with parity bit 1 -> rdata=0x01, rx_parity_err=1.
REQ-032 Assert rst_n low mid-TX at data bit 3 -> uart_txd=1 immediately; after release, tfull=0 and no further bits are output.
